// File: rtl/comparator_bist_sefunmi_pkg.sv
// comparator_pkg_sefunmi: shared constants and FSM encoding for the comparator BIST.
package comparator_pkg_sefunmi;

    localparam int DEF_WIDTH = 3;

    localparam int FLAG_GT = 5;
    localparam int FLAG_GE = 4;
    localparam int FLAG_LT = 3;
    localparam int FLAG_LE = 2;
    localparam int FLAG_EQ = 1;
    localparam int FLAG_NE = 0;

    typedef enum logic [2:0] {IDLE, DRIVE, WAIT, CHECK, DONE} stateT;

endpackage

// File: rtl/comparator_bist_sefunmi_if.sv
// comparator_bist_sefunmi_if: operand/flag bus between the BIST (master) and the comparator (slave).
interface comparator_bist_sefunmi_if
    import comparator_pkg_sefunmi::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic [WIDTH-1:0] valA;
    logic [WIDTH-1:0] valB;
    logic [5:0]       flags;

    modport master (output valA, output valB, input flags);
    modport slave  (input valA, input valB, output flags);
endinterface

// File: rtl/comparator_golden_sefunmi.sv
// comparator_golden_sefunmi: combinational unsigned reference comparator.
module comparator_golden_sefunmi
    import comparator_pkg_sefunmi::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [5:0]       flags
);
    always_comb begin
        flags          = '0;
        flags[FLAG_GT] = a > b;
        flags[FLAG_GE] = a >= b;
        flags[FLAG_LT] = a < b;
        flags[FLAG_LE] = a <= b;
        flags[FLAG_EQ] = a == b;
        flags[FLAG_NE] = a != b;
    end
endmodule

// File: rtl/comparator_bist_sefunmi.sv
// comparator_bist_sefunmi: sweeps every operand pair through the comparator and
// checks the returned flags against the golden model.
module comparator_bist_sefunmi
    import comparator_pkg_sefunmi::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    comparator_bist_sefunmi_if.master bus,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [2*WIDTH:0]       err_count,
    output logic [WIDTH-1:0]       fail_a,
    output logic [WIDTH-1:0]       fail_b
);
    localparam logic [3:0] settleLast = 4'(SETTLE == 0 ? 0 : SETTLE - 1);

    stateT            stateQ, stateD;
    logic [3:0]       settleCnt;
    logic             failSeen;
    logic [5:0]       expFlags;
    logic             launch, lastVec, mismatch;
    logic [2*WIDTH:0] errNext;

    comparator_golden_sefunmi #(.WIDTH(WIDTH)) golden (
        .a     (bus.valA),
        .b     (bus.valB),
        .flags (expFlags)
    );

    assign launch   = (stateQ == IDLE || stateQ == DONE) && start;
    assign lastVec  = &{bus.valA, bus.valB};
    assign mismatch = stateQ == CHECK && bus.flags != expFlags;
    assign errNext  = err_count + (2*WIDTH+1)'(mismatch);

    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            IDLE, DONE: stateD = start ? DRIVE : stateQ;
            DRIVE:      stateD = SETTLE == 0 ? CHECK : WAIT;
            WAIT:       stateD = settleCnt == settleLast ? CHECK : WAIT;
            CHECK:      stateD = lastVec ? DONE : DRIVE;
            default:    stateD = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ    <= IDLE;
            bus.valA  <= '0;
            bus.valB  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_a    <= '0;
            fail_b    <= '0;
            failSeen  <= 1'b0;
            settleCnt <= '0;
        end else begin
            stateQ    <= stateD;
            busy      <= stateD inside {DRIVE, WAIT, CHECK};
            done      <= stateD == DONE;
            pass      <= stateD == DONE && errNext == '0;
            settleCnt <= stateQ == WAIT ? settleCnt + 4'd1 : 4'd0;
            if (launch) begin
                bus.valA  <= '0;
                bus.valB  <= '0;
                err_count <= '0;
                fail_a    <= '0;
                fail_b    <= '0;
                failSeen  <= 1'b0;
            end else if (stateQ == CHECK) begin
                err_count <= errNext;
                if (mismatch && !failSeen) begin
                    fail_a   <= bus.valA;
                    fail_b   <= bus.valB;
                    failSeen <= 1'b1;
                end
                // valB is the inner loop, so a single increment of the pair walks the sweep
                if (!lastVec)
                    {bus.valA, bus.valB} <= {bus.valA, bus.valB} + (2*WIDTH)'(1);
            end
        end
    end
endmodule

// File: tb/tb_comparator_bist_sefunmi.sv
// tb_comparator_bist_sefunmi: three BIST instances (SETTLE 1/0/3) driving behavioural
// comparators; the first comparator can be made faulty.
module tb_comparator_bist_sefunmi;
    import comparator_pkg_sefunmi::*;

    localparam int W = 3;

    typedef struct {
        int err;
        int pass;
        int fa;
        int fb;
        int cycles;
        int launch;
    } expT;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] start = '0;
    int         fault = 0;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;

    logic         busy[3], done[3], pass[3];
    logic [2*W:0] errc[3];
    logic [W-1:0] fa[3], fb[3], va[3], vb[3];
    logic         prevDone[3] = '{default: 1'b0};
    expT          sb[3][$];

    comparator_bist_sefunmi_if #(.WIDTH(W)) bus0 ();
    comparator_bist_sefunmi_if #(.WIDTH(W)) bus1 ();
    comparator_bist_sefunmi_if #(.WIDTH(W)) bus2 ();

    function automatic logic [5:0] refFlags(logic [W-1:0] a, logic [W-1:0] b, int mode);
        logic [5:0] f;
        logic       t;
        f = {a > b, a >= b, a < b, a <= b, a == b, a != b};
        if (mode == 1) f[1] = 1'b0;
        if (mode == 2) begin
            t    = f[5];
            f[5] = f[3];
            f[3] = t;
        end
        return f;
    endfunction

    assign bus0.flags = refFlags(bus0.valA, bus0.valB, fault);
    assign bus1.flags = refFlags(bus1.valA, bus1.valB, 0);
    assign bus2.flags = refFlags(bus2.valA, bus2.valB, 0);
    assign va[0] = bus0.valA;
    assign vb[0] = bus0.valB;
    assign va[1] = bus1.valA;
    assign vb[1] = bus1.valB;
    assign va[2] = bus2.valA;
    assign vb[2] = bus2.valB;

    comparator_bist_sefunmi #(.WIDTH(W), .SETTLE(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .bus(bus0),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .err_count(errc[0]), .fail_a(fa[0]), .fail_b(fb[0])
    );
    comparator_bist_sefunmi #(.WIDTH(W), .SETTLE(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .bus(bus1),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .err_count(errc[1]), .fail_a(fa[1]), .fail_b(fb[1])
    );
    comparator_bist_sefunmi #(.WIDTH(W), .SETTLE(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .bus(bus2),
        .busy(busy[2]), .done(done[2]), .pass(pass[2]),
        .err_count(errc[2]), .fail_a(fa[2]), .fail_b(fb[2])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Monitor: every rising done retires one scoreboard entry for that instance
    always @(negedge clk) begin
        expT e;
        for (int i = 0; i < 3; i++) begin
            if (done[i] && !prevDone[i]) begin
                if (sb[i].size() == 0) begin
                    chk($sformatf("dut%0d_unexpected_done", i), 32'd1, 32'd0);
                end else begin
                    e = sb[i].pop_front();
                    chk($sformatf("dut%0d_err_count", i), 32'(errc[i]), e.err);
                    chk($sformatf("dut%0d_pass", i), 32'(pass[i]), e.pass);
                    chk($sformatf("dut%0d_fail_a", i), 32'(fa[i]), e.fa);
                    chk($sformatf("dut%0d_fail_b", i), 32'(fb[i]), e.fb);
                    chk($sformatf("dut%0d_busy_at_done", i), 32'(busy[i]), 32'd0);
                    chk($sformatf("dut%0d_latency", i), 32'(cyc - e.launch), e.cycles);
                end
            end
            prevDone[i] = done[i];
        end
    end

    task automatic launch(int i, int err, int p, int xa, int xb, int cycles);
        expT e;
        @(negedge clk) start[i] = 1'b1;
        @(negedge clk) start[i] = 1'b0;
        e = '{err: err, pass: p, fa: xa, fb: xb, cycles: cycles, launch: cyc};
        sb[i].push_back(e);
    endtask

    task automatic drain(string name);
        for (int n = 0; n < 1000 && (sb[0].size() + sb[1].size() + sb[2].size()) != 0; n++)
            @(negedge clk);
        chk({name, "_pending"}, 32'(sb[0].size() + sb[1].size() + sb[2].size()), 32'd0);
        for (int i = 0; i < 3; i++) sb[i].delete();
    endtask

    task automatic rstChk(string name);
        for (int i = 0; i < 3; i++)
            chk($sformatf("%s_dut%0d_outputs", name, i),
                32'({busy[i], done[i], pass[i], errc[i], fa[i], fb[i], va[i], vb[i]}), 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rstChk("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        launch(0, 0, 1, 0, 0, 192);
        launch(1, 0, 1, 0, 0, 128);
        launch(2, 0, 1, 0, 0, 320);
        drain("clean");
        fault = 1;
        launch(0, 8, 0, 0, 0, 192);
        drain("eq_stuck");
        fault = 2;
        launch(0, 56, 0, 0, 1, 192);
        drain("gt_lt_swap");
        fault = 0;
        launch(0, 0, 1, 0, 0, 192);
        repeat (18) @(negedge clk);
        chk("busy_mid_sweep", 32'(busy[0]), 32'd1);
        start[0] = 1'b1;
        @(negedge clk) start[0] = 1'b0;
        drain("restart_ignored");
        fault = 1;
        @(negedge clk) start[0] = 1'b1;
        @(negedge clk) start[0] = 1'b0;
        repeat (49) @(negedge clk);
        chk("errs_before_reset", 32'(errc[0] != '0), 32'd1);
        #1 rst_n = 1'b0;
        #1 rstChk("async_reset");
        @(negedge clk) rst_n = 1'b1;
        fault = 0;
        launch(0, 0, 1, 0, 0, 192);
        drain("after_reset");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
